// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle control unit (PC/IR owner, fetch/decode/exec/mem/wb sequencing).
// Optional overflow trap on ADD/SUB is compiled in when OVF_TRAP_EN is defined.
module mips_ctrl_fsm #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        alu_eq,
    input  logic        alu_v,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [15:0] imm,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic        wb_src,
    output logic        halted,
`ifdef OVF_TRAP_EN
    output logic        bus_err,
    output logic        ovf_trap
`else
    output logic        bus_err
`endif
);

    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [7:0] WAIT_LIMIT_C = WAIT_LIMIT[7:0];

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op == OP_ADD) || (op == OP_SUB) || (op == 4'h7);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    state_t      state_r, state_nx;
    logic [15:0] pc_r, pc_nx, ir_r, ir_nx, imm_r;
    logic [7:0]  wait_cnt_r, wait_nx;
    logic        bus_err_r, bus_err_nx, ovf_trap_r, ovf_nx;
    logic        mem_req_r, mem_we_r, mem_sel_r, alu_src_b_r, reg_we_r, wb_src_r, halted_r;
    logic [3:0]  alu_op_r;
    logic        mem_req_s, mem_we_s, mem_sel_s, alu_src_b_s, reg_we_s, wb_src_s, halted_s;
    logic [3:0]  alu_op_s, op_s, op_nx;
    logic        wait_hit_s;

    assign op_s       = ir_r[15:12];
    assign op_nx      = ir_nx[15:12];
    assign wait_hit_s = ((wait_cnt_r + 8'd1) == WAIT_LIMIT_C);

    // Next-state, PC/IR update, wait counter and sticky error flags.
    always_comb begin
        state_nx   = state_r;
        pc_nx      = pc_r;
        ir_nx      = ir_r;
        wait_nx    = 8'd0;
        bus_err_nx = bus_err_r;
        ovf_nx     = ovf_trap_r;
        case (state_r)
            ST_IDLE: state_nx = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_nx    = instr;
                    pc_nx    = pc_r + 16'd1;
                    state_nx = ST_DECODE;
                end else if (wait_hit_s) begin
                    bus_err_nx = 1'b1;
                    state_nx   = ST_HALT;
                end else begin
                    wait_nx = wait_cnt_r + 8'd1;
                end
            end
            ST_DECODE: begin
                if (is_rtype(op_s) || is_mem_op(op_s) || (op_s == OP_BNE)) begin
                    state_nx = ST_EXEC;
                end else begin
                    state_nx = ST_HALT;
                end
            end
            ST_EXEC: begin
`ifdef OVF_TRAP_EN
                if (((op_s == OP_ADD) || (op_s == OP_SUB)) && alu_v) begin
                    ovf_nx   = 1'b1;
                    state_nx = ST_HALT;
                end else
`endif
                if (is_rtype(op_s)) begin
                    state_nx = ST_WB;
                end else if (is_mem_op(op_s)) begin
                    state_nx = ST_MEM;
                end else if (op_s == OP_BNE) begin
                    // pc already points past the branch, so the offset is relative to pc+1
                    if (!alu_eq) begin
                        pc_nx = pc_r + sext4(ir_r[3:0]);
                    end else begin
                        pc_nx = pc_r;
                    end
                    state_nx = ST_FETCH;
                end else begin
                    state_nx = ST_HALT;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_nx = (op_s == OP_LW) ? ST_WB : ST_FETCH;
                end else if (wait_hit_s) begin
                    bus_err_nx = 1'b1;
                    state_nx   = ST_HALT;
                end else begin
                    wait_nx = wait_cnt_r + 8'd1;
                end
            end
            ST_WB:   state_nx = ST_FETCH;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_HALT;
        endcase
    end

    // Moore output decode for the upcoming state, so outputs leave a register.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_sel_s   = 1'b0;
        alu_op_s    = 4'h0;
        alu_src_b_s = 1'b0;
        reg_we_s    = 1'b0;
        wb_src_s    = 1'b0;
        halted_s    = 1'b0;
        case (state_nx)
            ST_FETCH: mem_req_s = 1'b1;
            ST_EXEC: begin
                alu_op_s    = op_nx;
                alu_src_b_s = is_mem_op(op_nx);
            end
            ST_MEM: begin
                alu_op_s    = op_nx;
                alu_src_b_s = 1'b1;
                mem_req_s   = 1'b1;
                mem_sel_s   = 1'b1;
                mem_we_s    = (op_nx == OP_SW);
            end
            ST_WB: begin
                alu_op_s = op_nx;
                reg_we_s = 1'b1;
                wb_src_s = (op_nx == OP_LW);
            end
            ST_HALT: halted_s = 1'b1;
            default: halted_s = 1'b0;
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            ir_r        <= 16'h0000;
            imm_r       <= 16'h0000;
            wait_cnt_r  <= 8'd0;
            bus_err_r   <= 1'b0;
            ovf_trap_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_sel_r   <= 1'b0;
            alu_op_r    <= 4'h0;
            alu_src_b_r <= 1'b0;
            reg_we_r    <= 1'b0;
            wb_src_r    <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nx;
            pc_r        <= pc_nx;
            ir_r        <= ir_nx;
            imm_r       <= sext4(ir_nx[3:0]);
            wait_cnt_r  <= wait_nx;
            bus_err_r   <= bus_err_nx;
            ovf_trap_r  <= ovf_nx;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_sel_r   <= mem_sel_s;
            alu_op_r    <= alu_op_s;
            alu_src_b_r <= alu_src_b_s;
            reg_we_r    <= reg_we_s;
            wb_src_r    <= wb_src_s;
            halted_r    <= halted_s;
        end
    end

    assign pc        = pc_r;
    assign ir        = ir_r;
    assign imm       = imm_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_sel   = mem_sel_r;
    assign alu_op    = alu_op_r;
    assign alu_src_b = alu_src_b_r;
    assign reg_we    = reg_we_r;
    assign wb_src    = wb_src_r;
    assign halted    = halted_r;
    assign bus_err   = bus_err_r;
`ifdef OVF_TRAP_EN
    assign ovf_trap  = ovf_trap_r;
`endif

endmodule
